// File: rtl/instr_encoder_if.sv
// Operation/write-port bundle between a program loader and instr_encoder.
// The master issues operations and sinks instruction words; the slave is the encoder.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op_class;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [31:0]       imm;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   word_count;
  logic              full;

  modport master (
    output in_valid, op_class, rs, rt, rd, shamt, funct, imm, wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data, word_count, full
  );

  modport slave (
    input  in_valid, op_class, rs, rt, rd, shamt, funct, imm, wr_ready,
    output in_ready, wr_en, wr_addr, wr_data, word_count, full
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs abstract MIPS operations into R/I-type words (expanding li) and streams
// them into instruction memory through a one-entry, backpressured output register.
module instr_encoder #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  instr_encoder_if.slave  bus_io
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [CntW-1:0] Cap = {1'b1, {ADDR_W{1'b0}}};

  localparam logic StIdle = 1'b0;
  localparam logic StLiLo = 1'b1;

  logic            state_q, state_d;
  logic            wr_en_q, wr_en_d;
  logic [31:0]     wr_data_q, wr_data_d;
  logic [31:0]     pend_q, pend_d;
  logic [CntW-1:0] count_q, count_d;

  logic [15:0]     imm_lo, imm_hi;
  logic [31:0]     first_word, ori_word;
  logic            need_two;
  logic            retire, slot_open, in_ready, accept;
  logic [CntW-1:0] free_slots;

  assign imm_lo   = bus_io.imm[15:0];
  assign imm_hi   = bus_io.imm[31:16];
  assign need_two = (bus_io.op_class == 3'b111) && (imm_hi != 16'h0000);
  assign ori_word = {6'b001101, bus_io.rt, bus_io.rt, imm_lo};

  always_comb begin
    first_word = '0;
    case (bus_io.op_class)
      3'b000: first_word = {6'b000000, bus_io.rs, bus_io.rt, bus_io.rd, bus_io.shamt,
                            bus_io.funct};
      3'b001: first_word = {6'b001000, bus_io.rs, bus_io.rt, imm_lo};
      3'b010: first_word = {6'b000100, bus_io.rs, bus_io.rt, imm_lo};
      3'b011: first_word = {6'b000101, bus_io.rs, bus_io.rt, imm_lo};
      3'b100: first_word = {6'b001111, 5'd0, bus_io.rt, imm_lo};
      3'b101: first_word = {6'b001101, bus_io.rs, bus_io.rt, imm_lo};
      3'b110: first_word = {6'b001011, bus_io.rs, bus_io.rt, imm_lo};
      3'b111: first_word = need_two ? {6'b001111, 5'd0, bus_io.rt, imm_hi}
                                    : {6'b001101, 5'd0, bus_io.rt, imm_lo};
    endcase
  end

  // A word sitting in the output register already owns a memory slot.
  assign free_slots = Cap - (count_q + CntW'(wr_en_q));
  assign retire     = wr_en_q & bus_io.wr_ready;
  assign slot_open  = ~wr_en_q | bus_io.wr_ready;
  assign in_ready   = (state_q == StIdle) & slot_open & (free_slots != '0);
  assign accept     = bus_io.in_valid & in_ready & (~need_two | (free_slots > CntW'(1)));

  always_comb begin
    state_d   = state_q;
    wr_en_d   = wr_en_q & ~retire;
    wr_data_d = wr_data_q;
    pend_d    = pend_q;
    count_d   = count_q + CntW'(retire);
    if (clear_i) begin
      state_d = StIdle;
      wr_en_d = 1'b0;
      count_d = '0;
    end else if (state_q == StLiLo) begin
      if (slot_open) begin
        wr_en_d   = 1'b1;
        wr_data_d = pend_q;
        state_d   = StIdle;
      end
    end else if (accept) begin
      wr_en_d   = 1'b1;
      wr_data_d = first_word;
      if (need_two) begin
        pend_d  = ori_word;
        state_d = StLiLo;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      pend_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      pend_q    <= pend_d;
      count_q   <= count_d;
    end
  end

  assign bus_io.in_ready   = in_ready;
  assign bus_io.wr_en      = wr_en_q;
  assign bus_io.wr_data    = wr_data_q;
  assign bus_io.wr_addr    = count_q[ADDR_W-1:0];
  assign bus_io.word_count = count_q;
  assign bus_io.full       = (count_q == Cap);

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder that produces the instruction words the main control decoder consumes. It accepts abstract operations over a valid/ready handshake and packs them into 32-bit R/I-type words. It expands the `li` pseudo-op into one or two words and writes the results sequentially into instruction memory through a backpressured write port. It sits in the test/boot path, ahead of instruction memory, and loads programs into the single-cycle CPU.

## Interface
- ADDR_W, 10, word-address width of instruction memory; capacity 2^ADDR_W words
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous clear of address counter and pending work
- in_valid_i  in  1  operation valid
- in_ready_o  out  1  encoder can accept an operation
- op_class_i  in  3  000 R-type, 001 addi, 010 beq, 011 bne, 100 lui, 101 ori, 110 sltiu, 111 li (pseudo)
- rs_i, rt_i, rd_i, shamt_i  in  5 each  register/shift fields
- funct_i  in  6  R-type function field
- imm_i  in  32  immediate; bits [15:0] for I-types, full 32 bits for li
- wr_en_o  out  1  write word valid
- wr_ready_i  in  1  memory accepts word this cycle
- wr_addr_o  out  ADDR_W  word address of current write
- wr_data_o  out  32  encoded instruction
- word_count_o  out  ADDR_W+1  words written since reset/clear
- full_o  out  1  word_count_o == 2^ADDR_W

## Operation
- Encoding:
  - R-type: {6'b000000, rs, rt, rd, shamt, funct}.
  - I-type: {opcode, rs, rt, imm[15:0]}, with opcodes addi 001000, beq 000100, bne 000101, lui 001111 (rs forced to 0), ori 001101, sltiu 001011.
  - Unused input fields are ignored.
- li expansion:
  - imm[31:16] != 0: emit lui rt,imm[31:16], then ori rt,rt,imm[15:0].
  - imm[31:16] == 0: emit a single ori rt,$0,imm[15:0].
- FSM:
  - IDLE: accepts input.
  - LI_LO: the lui word is in the output register and the ori word is pending.
  - LI_LO → IDLE once the ori word has been loaded into the output register.
- Output register:
  - One-entry buffer holding wr_en_o/wr_data_o/wr_addr_o.
  - A word retires on wr_en_o & wr_ready_i.
  - Data and address hold stable while wr_en_o=1 and wr_ready_i=0.
- Address and count:
  - wr_addr_o = word_count_o[ADDR_W-1:0] of the word being presented.
  - word_count_o increments by 1 per retired word and never wraps.
- in_ready_o = state==IDLE & (!wr_en_o | wr_ready_i) & free slots ≥ 1.
  - A two-word li with exactly one free slot is held off: in_ready_o stays 1, but the op is not accepted. Accept requires in_valid_i & in_ready_o & (need ≤ free slots).
  - Two-word li is accepted only when ≥ 2 slots are free.
- full_o: no further acceptance. Writes already in flight complete.
- clear_i:
  - Next cycle: word_count_o=0, wr_en_o=0, state=IDLE.
  - Any pending li second word and any unretired word are discarded.
  - Has priority over accept in the same cycle.

## Timing
- Reset values: in_ready_o=1, wr_en_o=0, wr_addr_o=0, wr_data_o=0, word_count_o=0, full_o=0, state IDLE. Reset takes effect immediately, regardless of clock.
- Latency: an op accepted at edge N presents wr_en_o=1 with its first word after edge N (cycle N+1).
- With wr_ready_i held high, throughput is 1 word/cycle.
  - Single-word ops: back-to-back, one per cycle.
  - Two-word li: the lui word retires in cycle N+1 and the ori word is presented in N+2. in_ready_o=0 during N+1.
- Backpressure: while wr_ready_i=0, the output register holds, in_ready_o=0, and the LI_LO state persists.
- Simultaneous retire and accept in one cycle is allowed: the new word is loaded on the same edge the old one retires.
- word_count_o and full_o update on the edge where a word retires.
- Reset asserted mid-li drops the second word.

## Test plan
- addi, rs=0, rt=8, imm=5 with wr_ready_i=1 → wr_data_o=0x20080005 at wr_addr_o=0 one cycle after accept; word_count_o=1.
- R-type, rs=8, rt=9, rd=10, shamt=0, funct=0x20 → 0x01095020; then beq rs=8, rt=9, imm=0xFFFF → 0x1109FFFF at address 1, back-to-back.
- li rt=8, imm=0x12345678 → 0x3C081234 at address 0, then 0x35085678 at address 1; in_ready_o=0 for exactly one cycle. li rt=8, imm=0x00000042 → single word 0x34080042.
- Backpressure: hold wr_ready_i=0 for 3 cycles during the li lui word → data/address stable, no count change. Release → both words retire in order.
- ADDR_W=2: send 3 single ops, then li 0x12345678 → li is not accepted (one slot left). A following ori is accepted; full_o=1 and word_count_o=4 after it retires; in_ready_o=0 afterward.
- clear_i asserted while in LI_LO → next cycle wr_en_o=0, word_count_o=0. A subsequent addi is written at address 0. rst_i low mid-stream → all outputs return to reset values immediately.
